dctlb_l1_ack_arb: RTL and testbench

Stage directly downstream of the DC TLB. Buffers the TLB's two ack streams (ack0/ack1) and its TLB-index invalidate commands (dctlbtol1_cmd), then arbitrates them into the single request slot of the L1 tag pipe in dcache_pipe. Buffered acks whose TLB index is invalidated before they issue are flagged stale so L1 never uses a recycled index silently.

---
 rtl/dctlb_l1_ack_arb_pkg.sv | 43 ++++
 rtl/dctlb_l1_ack_arb_fifo2.sv | 70 +++++++
 rtl/dctlb_l1_ack_arb.sv | 141 ++++++++++++++
 tb/tb_dctlb_l1_ack_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dctlb_l1_ack_arb_pkg.sv
// Shared types and constants for the DC TLB -> L1 tag pipe ack/cmd arbiter.
// The TLB index sits in the low bits of both the ack and the cmd payloads.
package dctlb_l1_ack_arb_pkg;

  localparam int ACK_W         = 64;
  localparam int CMD_W         = 16;
  localparam int DCTLB_IDX_W   = 5;
  localparam int IDX_W         = DCTLB_IDX_W;
  localparam int MAX_CMD_BURST = 4;
  localparam int STREAK_W      = $clog2(MAX_CMD_BURST + 1);

  localparam int ACK_IDX_LSB = 0;
  localparam int CMD_IDX_LSB = 0;

  typedef logic [ACK_W-1:0]       I_dctlbtol1_ack_type;
  typedef logic [CMD_W-1:0]       I_dctlbtol1_cmd_type;
  typedef logic [DCTLB_IDX_W-1:0] dctlb_idx_t;

  // Buffered ack: the stale flag is kept as the MSB so the FIFO can set it in place.
  typedef struct packed {
    logic                stale;
    I_dctlbtol1_ack_type ack;
  } ack_entry_t;

  localparam int ACK_ENTRY_W = $bits(ack_entry_t);

  typedef struct packed {
    logic                is_cmd;
    logic                port;
    logic                stale;
    I_dctlbtol1_ack_type ack;
    I_dctlbtol1_cmd_type cmd;
  } l1_req_t;

  function automatic dctlb_idx_t cmd_idx(input I_dctlbtol1_cmd_type c);
    return c[CMD_IDX_LSB +: DCTLB_IDX_W];
  endfunction

  function automatic dctlb_idx_t ack_idx(input I_dctlbtol1_ack_type a);
    return a[ACK_IDX_LSB +: DCTLB_IDX_W];
  endfunction

endpackage

// File: rtl/dctlb_l1_ack_arb_fifo2.sv
// Two-entry valid/retry FIFO. Entries whose key field matches match_key while
// match_en is high get their MSB (flag bit) set in place.
module dctlb_fifo2 #(
  parameter int W       = 8,
  parameter int KEY_LSB = 0,
  parameter int KEY_W   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_retry,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output logic [W-1:0]     out_data,
  input  logic             match_en,
  input  logic [KEY_W-1:0] match_key
);

  logic [W-1:0] mem [2];
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   slot_valid;
  logic         enq;
  logic         deq;

  // Full is taken from the registered count only, so a dequeue never frees a
  // slot for an enqueue in the same cycle.
  assign in_retry  = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign enq       = in_valid && !in_retry;
  assign deq       = out_valid && !out_retry;

  always_comb begin
    slot_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      slot_valid[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count + {1'b0, enq} - {1'b0, deq};
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone decide which
  // entries are meaningful, and a flag is only set on an occupied slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (enq && (wr_ptr == 1'(i))) begin
        mem[i] <= in_data;
      end else if (match_en && slot_valid[i] &&
                   (mem[i][KEY_LSB +: KEY_W] == match_key)) begin
        mem[i][W-1] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dctlb_l1_ack_arb.sv
// Buffers the DC TLB ack0/ack1/cmd streams and arbitrates them into the single
// L1 tag pipe request register, flagging acks whose TLB index was invalidated.
module dctlb_l1_ack_arb
  import dctlb_l1_ack_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                dctlbtol1_ack0_valid,
  output logic                dctlbtol1_ack0_retry,
  input  I_dctlbtol1_ack_type dctlbtol1_ack0,
  input  logic                dctlbtol1_ack1_valid,
  output logic                dctlbtol1_ack1_retry,
  input  I_dctlbtol1_ack_type dctlbtol1_ack1,
  input  logic                dctlbtol1_cmd_valid,
  output logic                dctlbtol1_cmd_retry,
  input  I_dctlbtol1_cmd_type dctlbtol1_cmd,
  output logic                l1pipe_req_valid,
  input  logic                l1pipe_req_retry,
  output logic                l1pipe_req_is_cmd,
  output logic                l1pipe_req_port,
  output logic                l1pipe_req_stale,
  output I_dctlbtol1_ack_type l1pipe_req_ack,
  output I_dctlbtol1_cmd_type l1pipe_req_cmd
);

  ack_entry_t          a0_in, a1_in, a0_head, a1_head;
  I_dctlbtol1_cmd_type c_head;
  logic                a0_valid, a1_valid, c_valid;
  logic                a0_deq, a1_deq;

  l1_req_t             r_q, r_next;
  logic                r_valid;
  logic                rr;
  logic [STREAK_W-1:0] cmd_streak;

  logic                load, any_ack, ack_starved;
  logic                grant_cmd, grant_ack, ack_port;
  dctlb_idx_t          inval_idx;

  assign load        = !r_valid || !l1pipe_req_retry;
  assign any_ack     = a0_valid || a1_valid;
  assign ack_starved = (cmd_streak == STREAK_W'(MAX_CMD_BURST)) && any_ack;
  assign grant_cmd   = load && c_valid && !ack_starved;
  assign grant_ack   = load && any_ack && !grant_cmd;
  assign ack_port    = (rr ? a1_valid : a0_valid) ? rr : ~rr;
  assign a0_deq      = grant_ack && !ack_port;
  assign a1_deq      = grant_ack && ack_port;
  assign inval_idx   = cmd_idx(c_head);

  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned and a latch is never inferred.
  always_comb begin
    a0_in       = '0;
    a1_in       = '0;
    a0_in.ack   = dctlbtol1_ack0;
    a1_in.ack   = dctlbtol1_ack1;
    // An ack arriving in the cycle its index is invalidated is already stale.
    a0_in.stale = grant_cmd && (ack_idx(dctlbtol1_ack0) == inval_idx);
    a1_in.stale = grant_cmd && (ack_idx(dctlbtol1_ack1) == inval_idx);
  end

  always_comb begin
    r_next = '0;
    if (grant_cmd) begin
      r_next.is_cmd = 1'b1;
      r_next.cmd    = c_head;
    end else if (grant_ack) begin
      r_next.port  = ack_port;
      r_next.stale = ack_port ? a1_head.stale : a0_head.stale;
      r_next.ack   = ack_port ? a1_head.ack   : a0_head.ack;
    end
  end

  dctlb_fifo2 #(.W(ACK_ENTRY_W), .KEY_LSB(ACK_IDX_LSB), .KEY_W(DCTLB_IDX_W)) u_a0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (dctlbtol1_ack0_valid),
    .in_retry  (dctlbtol1_ack0_retry),
    .in_data   (a0_in),
    .out_valid (a0_valid),
    .out_retry (!a0_deq),
    .out_data  (a0_head),
    .match_en  (grant_cmd),
    .match_key (inval_idx)
  );

  dctlb_fifo2 #(.W(ACK_ENTRY_W), .KEY_LSB(ACK_IDX_LSB), .KEY_W(DCTLB_IDX_W)) u_a1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (dctlbtol1_ack1_valid),
    .in_retry  (dctlbtol1_ack1_retry),
    .in_data   (a1_in),
    .out_valid (a1_valid),
    .out_retry (!a1_deq),
    .out_data  (a1_head),
    .match_en  (grant_cmd),
    .match_key (inval_idx)
  );

  dctlb_fifo2 #(.W(CMD_W), .KEY_LSB(CMD_IDX_LSB), .KEY_W(DCTLB_IDX_W)) u_c (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (dctlbtol1_cmd_valid),
    .in_retry  (dctlbtol1_cmd_retry),
    .in_data   (dctlbtol1_cmd),
    .out_valid (c_valid),
    .out_retry (!grant_cmd),
    .out_data  (c_head),
    .match_en  (1'b0),
    .match_key ('0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_q        <= '0;
      rr         <= 1'b0;
      cmd_streak <= '0;
    end else begin
      if (load) begin
        r_valid <= grant_cmd || grant_ack;
        r_q     <= r_next;
      end
      if (grant_ack) rr <= ~ack_port;
      // The streak only measures how long a waiting ack has been starved.
      if (grant_ack || !any_ack) begin
        cmd_streak <= '0;
      end else if (grant_cmd && (cmd_streak != STREAK_W'(MAX_CMD_BURST))) begin
        cmd_streak <= cmd_streak + 1'b1;
      end
    end
  end

  assign l1pipe_req_valid  = r_valid;
  assign l1pipe_req_is_cmd = r_q.is_cmd;
  assign l1pipe_req_port   = r_q.port;
  assign l1pipe_req_stale  = r_q.stale;
  assign l1pipe_req_ack    = r_q.ack;
  assign l1pipe_req_cmd    = r_q.cmd;

endmodule

// File: tb/tb_dctlb_l1_ack_arb.sv
// Directed bench for dctlb_l1_ack_arb: latency, round-robin, cmd burst limit,
// stale marking, back-pressure with a payload scoreboard, and async reset.
module tb_dctlb_l1_ack_arb;
  import dctlb_l1_ack_arb_pkg::*;

  localparam logic [63:0] ACK0_BASE = 64'hA000_0000_0000_0000;
  localparam logic [63:0] ACK1_BASE = 64'hB000_0000_0000_0000;
  localparam logic [15:0] CMD_BASE  = 16'hC000;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                ack0_valid = 1'b0, ack1_valid = 1'b0, cmd_valid = 1'b0;
  logic                ack0_retry, ack1_retry, cmd_retry;
  I_dctlbtol1_ack_type ack0 = '0, ack1 = '0;
  I_dctlbtol1_cmd_type cmd = '0;
  logic                req_valid, req_retry = 1'b0;
  logic                req_is_cmd, req_port, req_stale;
  I_dctlbtol1_ack_type req_ack;
  I_dctlbtol1_cmd_type req_cmd;

  int total = 0;
  int bad   = 0;
  bit auto0, auto1, autoc, sb_on;
  int cnt0, cnt1, cntc;
  I_dctlbtol1_ack_type q0[$], q1[$];
  I_dctlbtol1_cmd_type qc[$];

  logic [63:0] t3_exp [7];
  bit          t3_cmd [7];

  always #5 clk = ~clk;

  dctlb_l1_ack_arb dut (
    .clk                  (clk),
    .reset                (reset),
    .dctlbtol1_ack0_valid (ack0_valid),
    .dctlbtol1_ack0_retry (ack0_retry),
    .dctlbtol1_ack0       (ack0),
    .dctlbtol1_ack1_valid (ack1_valid),
    .dctlbtol1_ack1_retry (ack1_retry),
    .dctlbtol1_ack1       (ack1),
    .dctlbtol1_cmd_valid  (cmd_valid),
    .dctlbtol1_cmd_retry  (cmd_retry),
    .dctlbtol1_cmd        (cmd),
    .l1pipe_req_valid     (req_valid),
    .l1pipe_req_retry     (req_retry),
    .l1pipe_req_is_cmd    (req_is_cmd),
    .l1pipe_req_port      (req_port),
    .l1pipe_req_stale     (req_stale),
    .l1pipe_req_ack       (req_ack),
    .l1pipe_req_cmd       (req_cmd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Records the handshakes of the coming edge, advances one cycle, then
  // refreshes the payload of any streaming input that was just taken.
  task automatic step();
    bit a0, a1, ac;
    a0 = ack0_valid && !ack0_retry;
    a1 = ack1_valid && !ack1_retry;
    ac = cmd_valid && !cmd_retry;
    if (sb_on) begin
      if (a0) q0.push_back(ack0);
      if (a1) q1.push_back(ack1);
      if (ac) qc.push_back(cmd);
      if (req_valid && !req_retry) begin
        if (req_is_cmd) begin
          check("sb_cmd_queued", 64'(qc.size() != 0), 64'd1);
          if (qc.size() != 0) check("sb_cmd", 64'(req_cmd), 64'(qc.pop_front()));
        end else if (!req_port) begin
          check("sb_ack0_queued", 64'(q0.size() != 0), 64'd1);
          if (q0.size() != 0) check("sb_ack0", req_ack, q0.pop_front());
        end else begin
          check("sb_ack1_queued", 64'(q1.size() != 0), 64'd1);
          if (q1.size() != 0) check("sb_ack1", req_ack, q1.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (auto0 && a0) begin cnt0++; ack0 = ACK0_BASE | 64'(cnt0); end
    if (auto1 && a1) begin cnt1++; ack1 = ACK1_BASE | 64'(cnt1); end
    if (autoc && ac) begin cntc++; cmd = CMD_BASE | 16'(cntc); end
  endtask

  task automatic start_streams(input bit s0, input bit s1, input bit sc);
    auto0 = s0; ack0_valid = s0; ack0 = ACK0_BASE | 64'(cnt0);
    auto1 = s1; ack1_valid = s1; ack1 = ACK1_BASE | 64'(cnt1);
    autoc = sc; cmd_valid  = sc; cmd  = CMD_BASE | 16'(cntc);
  endtask

  task automatic stop_streams();
    auto0 = 0; auto1 = 0; autoc = 0;
    ack0_valid = 0; ack1_valid = 0; cmd_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stop_streams();
    req_retry = 1'b0;
    sb_on = 0;
    cnt0 = 0; cnt1 = 0; cntc = 0;
    q0.delete(); q1.delete(); qc.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t3_exp = '{64'hC000, 64'hC001, 64'hC002, 64'hC003,
               64'hAAAA_0000_0000_001F, 64'hC004, 64'hC005};
    t3_cmd = '{1, 1, 1, 1, 0, 1, 1};

    // Reset state and single-ack latency.
    do_reset();
    check("rst_valid", req_valid, 0);
    check("rst_ack0_retry", ack0_retry, 0);
    check("rst_ack1_retry", ack1_retry, 0);
    check("rst_cmd_retry", cmd_retry, 0);
    check("rst_is_cmd", req_is_cmd, 0);
    check("rst_port", req_port, 0);
    check("rst_stale", req_stale, 0);
    check("rst_ack", req_ack, 0);
    check("rst_cmd", 64'(req_cmd), 0);

    ack0_valid = 1; ack0 = 64'h0123_4567_89AB_CD05;
    step();
    ack0_valid = 0;
    check("t1_cycle1_valid", req_valid, 0);
    step();
    check("t1_valid", req_valid, 1);
    check("t1_is_cmd", req_is_cmd, 0);
    check("t1_port", req_port, 0);
    check("t1_stale", req_stale, 0);
    check("t1_ack", req_ack, 64'h0123_4567_89AB_CD05);
    check("t1_cmd_zero", 64'(req_cmd), 0);
    step();
    check("t1_drained", req_valid, 0);

    // Both ack ports streaming: strict alternation starting at port 0.
    do_reset();
    sb_on = 1;
    start_streams(1, 1, 0);
    step(); step();
    for (int i = 0; i < 6; i++) begin
      check("t2_valid", req_valid, 1);
      check("t2_port", req_port, 64'(i % 2));
      step();
    end
    stop_streams();
    repeat (8) step();
    check("t2_q0_empty", 64'(q0.size()), 0);
    check("t2_q1_empty", 64'(q1.size()), 0);
    check("t2_idle", req_valid, 0);

    // Cmd streaming with one pending ack: four cmds, the ack, then cmds.
    do_reset();
    start_streams(0, 0, 1);
    ack0_valid = 1; ack0 = 64'hAAAA_0000_0000_001F;
    step();
    ack0_valid = 0;
    step();
    for (int i = 0; i < 7; i++) begin
      check("t3_valid", req_valid, 1);
      check("t3_is_cmd", req_is_cmd, 64'(t3_cmd[i]));
      if (t3_cmd[i]) begin
        check("t3_cmd", 64'(req_cmd), t3_exp[i]);
        check("t3_cmd_ack_zero", req_ack, 0);
      end else begin
        check("t3_ack", req_ack, t3_exp[i]);
        check("t3_ack_port", req_port, 0);
        check("t3_ack_cmd_zero", 64'(req_cmd), 0);
      end
      step();
    end
    stop_streams();

    // Stale marking: buffered idx 3 and same-cycle idx 3 go stale, idx 4 does not.
    do_reset();
    ack0_valid = 1; ack0 = 64'h1111_0000_0000_0003;
    cmd_valid  = 1; cmd  = 16'h5003;
    step();
    ack0 = 64'h2222_0000_0000_0004;
    ack1_valid = 1; ack1 = 64'h3333_0000_0000_0003;
    cmd_valid = 0;
    step();
    ack0_valid = 0; ack1_valid = 0;
    req_retry = 1;
    check("t4_cmd_valid", req_valid, 1);
    check("t4_cmd_is_cmd", req_is_cmd, 1);
    check("t4_cmd", 64'(req_cmd), 64'h5003);
    step();
    check("t4_hold1", 64'(req_cmd), 64'h5003);
    step();
    check("t4_hold2_valid", req_valid, 1);
    check("t4_hold2", 64'(req_cmd), 64'h5003);
    req_retry = 0;
    step();
    check("t4_x_ack", req_ack, 64'h1111_0000_0000_0003);
    check("t4_x_port", req_port, 0);
    check("t4_x_stale", req_stale, 1);
    step();
    check("t4_z_ack", req_ack, 64'h3333_0000_0000_0003);
    check("t4_z_port", req_port, 1);
    check("t4_z_stale", req_stale, 1);
    step();
    check("t4_y_ack", req_ack, 64'h2222_0000_0000_0004);
    check("t4_y_port", req_port, 0);
    check("t4_y_stale", req_stale, 0);
    step();
    check("t4_idle", req_valid, 0);

    // Long L1 back-pressure with everything streaming.
    do_reset();
    sb_on = 1;
    req_retry = 1;
    start_streams(1, 1, 1);
    step(); step(); step();
    check("t5_ack0_retry", ack0_retry, 1);
    check("t5_ack1_retry", ack1_retry, 1);
    check("t5_cmd_retry", cmd_retry, 1);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", req_valid, 1);
      check("t5_hold_is_cmd", req_is_cmd, 1);
      check("t5_hold_cmd", 64'(req_cmd), 64'(CMD_BASE));
      check("t5_hold_retry", 64'({ack0_retry, ack1_retry, cmd_retry}), 64'b111);
      step();
    end
    req_retry = 0;
    repeat (30) step();
    stop_streams();
    repeat (20) step();
    check("t5_q0_empty", 64'(q0.size()), 0);
    check("t5_q1_empty", 64'(q1.size()), 0);
    check("t5_qc_empty", 64'(qc.size()), 0);
    check("t5_idle", req_valid, 0);

    // Asynchronous reset mid-stream, then a fresh transfer.
    do_reset();
    start_streams(1, 1, 0);
    repeat (4) step();
    check("t6_pre_valid", req_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", req_valid, 0);
    check("t6_async_retry", 64'({ack0_retry, ack1_retry, cmd_retry}), 0);
    check("t6_async_ack", req_ack, 0);
    check("t6_async_port", req_port, 0);
    do_reset();
    ack1_valid = 1; ack1 = 64'h0000_0000_0000_0077;
    step();
    ack1_valid = 0;
    check("t6_cycle1_valid", req_valid, 0);
    step();
    check("t6_valid", req_valid, 1);
    check("t6_port", req_port, 1);
    check("t6_ack", req_ack, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
